// File: rtl/trail_sequencer_if.sv
// Bundle of the trail sequencer button inputs and trail outputs.
// The master side drives the buttons and abort; the slave side owns the trail.
interface trail_sequencer_if;
    logic       btn_go;
    logic       btn_red;
    logic       abort;
    logic [3:0] phase;
    logic [6:0] green_x;
    logic [6:0] green_y;
    logic [6:0] red_x;
    logic [6:0] red_y;
    logic       busy;
    logic       done;

    modport master (
        output btn_go,
        output btn_red,
        output abort,
        input  phase,
        input  green_x,
        input  green_y,
        input  red_x,
        input  red_y,
        input  busy,
        input  done
    );

    modport slave (
        input  btn_go,
        input  btn_red,
        input  abort,
        output phase,
        output green_x,
        output green_y,
        output red_x,
        output red_y,
        output busy,
        output done
    );
endinterface

// File: rtl/trail_sequencer.sv
// Two-square trail sequencer: a slow green lap, a dwell-punctuated path,
// then a fast red lap started by a second button.
module trail_sequencer #(
    parameter int STEP_DIV    = 1666667,
    parameter int FAST_DIV    = 1000000,
    parameter int DWELL_STEPS = 45,
    parameter int MIN_X       = 6,
    parameter int MAX_X       = 90,
    parameter int MIN_Y       = 4,
    parameter int MAX_Y       = 60,
    parameter int SIZE        = 15
) (
    input  logic              clk,
    input  logic              reset,
    trail_sequencer_if.slave  bus
);
    localparam int SW = $clog2(STEP_DIV + 1);
    localparam int FW = $clog2(FAST_DIV + 1);
    localparam int DW = $clog2(DWELL_STEPS + 1);

    localparam logic [SW-1:0] SLOW_LAST  = SW'(STEP_DIV - 1);
    localparam logic [FW-1:0] FAST_LAST  = FW'(FAST_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_STEPS - 1);

    localparam logic [6:0] X0    = 7'(MIN_X);
    localparam logic [6:0] Y0    = 7'(MIN_Y);
    localparam logic [6:0] XR    = 7'(MAX_X - SIZE);
    localparam logic [6:0] YB    = 7'(MAX_Y - SIZE);
    localparam logic [6:0] X0_P2 = 7'(MIN_X + 2);
    localparam logic [6:0] Y0_P2 = 7'(MIN_Y + 2);
    localparam logic [6:0] XR_M2 = 7'(MAX_X - SIZE - 2);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        G_RIGHT  = 4'd1,
        G_DWELL1 = 4'd2,
        G_DOWN   = 4'd3,
        G_DWELL2 = 4'd4,
        G_LEFT   = 4'd5,
        G_DWELL3 = 4'd6,
        ARMED    = 4'd7,
        R_RIGHT  = 4'd8,
        R_UP     = 4'd9,
        R_LEFT   = 4'd10
    } phase_e;

    phase_e        phase_q, phase_d;
    phase_e        dwell_next;
    logic [SW-1:0] slow_cnt_q, slow_cnt_d;
    logic [FW-1:0] fast_cnt_q, fast_cnt_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [6:0]    gx_q, gx_d;
    logic [6:0]    gy_q, gy_d;
    logic [6:0]    rx_q, rx_d;
    logic [6:0]    ry_q, ry_d;
    logic          done_q, done_d;
    logic [1:0]    go_sync_q, go_sync_d;
    logic [1:0]    red_sync_q, red_sync_d;
    logic          go_prev_q, go_prev_d;
    logic          red_prev_q, red_prev_d;
    logic [2:0]    prime_q, prime_d;
    logic          slow_tick;
    logic          fast_tick;
    logic          go_edge;
    logic          red_edge;

    always_comb begin
        slow_tick  = (slow_cnt_q == SLOW_LAST);
        fast_tick  = (fast_cnt_q == FAST_LAST);
        slow_cnt_d = slow_tick ? '0 : slow_cnt_q + 1'b1;
        fast_cnt_d = fast_tick ? '0 : fast_cnt_q + 1'b1;
    end

    // prime_q gates edges until the previous-sample flop holds a real
    // post-reset sample, so a button held through reset is not an edge.
    always_comb begin
        go_sync_d  = {go_sync_q[0], bus.btn_go};
        red_sync_d = {red_sync_q[0], bus.btn_red};
        go_prev_d  = go_sync_q[1];
        red_prev_d = red_sync_q[1];
        prime_d    = {prime_q[1:0], 1'b1};
        go_edge    = prime_q[2] & go_sync_q[1] & ~go_prev_q;
        red_edge   = prime_q[2] & red_sync_q[1] & ~red_prev_q;
    end

    always_comb begin
        unique case (1'b1)
            phase_q == G_DWELL1: dwell_next = G_DOWN;
            phase_q == G_DWELL2: dwell_next = G_LEFT;
            default:             dwell_next = ARMED;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        dwell_d = dwell_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            phase_d = IDLE;
            dwell_d = '0;
            gx_d    = X0;
            gy_d    = Y0;
            rx_d    = X0;
            ry_d    = YB;
        end else begin
            unique case (phase_q)
                IDLE: begin
                    gx_d = X0;
                    gy_d = Y0;
                    rx_d = X0;
                    ry_d = YB;
                    if (go_edge) begin
                        phase_d = G_RIGHT;
                    end
                end
                G_RIGHT: begin
                    if (slow_tick) begin
                        if (gx_q < XR) gx_d = gx_q + 7'd1;
                        else           phase_d = G_DWELL1;
                    end
                end
                G_DOWN: begin
                    if (slow_tick) begin
                        if (gy_q < YB) gy_d = gy_q + 7'd1;
                        else           phase_d = G_DWELL2;
                    end
                end
                G_LEFT: begin
                    if (slow_tick) begin
                        if (gx_q > X0) gx_d = gx_q - 7'd1;
                        else           phase_d = G_DWELL3;
                    end
                end
                G_DWELL1, G_DWELL2, G_DWELL3: begin
                    if (slow_tick) begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = '0;
                            phase_d = dwell_next;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (red_edge) begin
                        phase_d = R_RIGHT;
                    end
                end
                R_RIGHT: begin
                    if (fast_tick) begin
                        if (rx_q >= XR)         phase_d = R_UP;
                        else if (rx_q >= XR_M2) rx_d = XR;
                        else                    rx_d = rx_q + 7'd2;
                    end
                end
                R_UP: begin
                    if (fast_tick) begin
                        if (ry_q <= Y0)         phase_d = R_LEFT;
                        else if (ry_q <= Y0_P2) ry_d = Y0;
                        else                    ry_d = ry_q - 7'd2;
                    end
                end
                R_LEFT: begin
                    if (fast_tick) begin
                        if (rx_q <= X0) begin
                            phase_d = IDLE;
                            done_d  = 1'b1;
                            gx_d    = X0;
                            gy_d    = Y0;
                            ry_d    = YB;
                        end else if (rx_q <= X0_P2) begin
                            rx_d = X0;
                        end else begin
                            rx_d = rx_q - 7'd2;
                        end
                    end
                end
                default: begin
                    phase_d = IDLE;
                    dwell_d = '0;
                    gx_d    = X0;
                    gy_d    = Y0;
                    rx_d    = X0;
                    ry_d    = YB;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= IDLE;
            slow_cnt_q <= '0;
            fast_cnt_q <= '0;
            dwell_q    <= '0;
            gx_q       <= X0;
            gy_q       <= Y0;
            rx_q       <= X0;
            ry_q       <= YB;
            done_q     <= 1'b0;
            go_sync_q  <= '0;
            red_sync_q <= '0;
            go_prev_q  <= 1'b0;
            red_prev_q <= 1'b0;
            prime_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            slow_cnt_q <= slow_cnt_d;
            fast_cnt_q <= fast_cnt_d;
            dwell_q    <= dwell_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            done_q     <= done_d;
            go_sync_q  <= go_sync_d;
            red_sync_q <= red_sync_d;
            go_prev_q  <= go_prev_d;
            red_prev_q <= red_prev_d;
            prime_q    <= prime_d;
        end
    end

    assign bus.phase   = phase_q;
    assign bus.green_x = gx_q;
    assign bus.green_y = gy_q;
    assign bus.red_x   = rx_q;
    assign bus.red_y   = ry_q;
    assign bus.busy    = (phase_q != IDLE) && (phase_q != ARMED);
    assign bus.done    = done_q;
endmodule
